bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Read-side master for the BRAM port, sitting directly upstream of the convolution datapath.
- On a start command it fetches a strided sequence of 32-bit words from BRAM through the memory interface, which uses byte addressing and has a one-cycle registered read latency.
- It delivers the words in order on a valid/ready stream and absorbs backpressure in a small credit-managed FIFO.
- It never writes BRAM.

Parameters:
- DATA_W, `DATA_BUS_WIDTH (32), width of BRAM words and output stream data.
- ADDR_W, `ADDR_BUS_WIDTH (32), byte-address width.
- LEN_W, 16, width of the word-count field.
- FIFO_DEPTH, 4, output buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  command pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of the first word.
- len  in  LEN_W  number of words to read.
- stride  in  ADDR_W  byte increment between consecutive words.
- abort  in  1  synchronous cancel of the current command.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a command completes.
- bram_en  out  1  BRAM enable; a read is issued in each cycle it is high.
- bram_addr  out  ADDR_W  byte address presented to BRAM.
- bram_W_req  out  `W_REQ_WIDTH  write request; each bit is held at ~`WRITE_ENB at all times.
- bram_W_data  out  DATA_W  tied to 0.
- bram_R_data  in  DATA_W  read data, valid in the cycle after the bram_en cycle.
- m_valid  out  1  stream data valid.
- m_data  out  DATA_W  stream word.
- m_last  out  1  marks the final word of the command; qualified by m_valid.
- m_ready  in  1  downstream accept.

Behaviour:
- Reset: state IDLE, FIFO empty, counters 0. Outputs busy, done, bram_en, m_valid and m_last are 0; bram_addr, m_data and bram_W_data are 0. Reset may assert in any state and discards everything, including any in-flight read.
- States:
  - IDLE -> RUN: start=1 and len!=0. Latch base_addr, len and stride; issue count = 0; beat count = 0.
  - IDLE -> DONE: start=1 and len==0. No BRAM access is made.
  - RUN -> DRAIN: issue count reaches len.
  - DRAIN -> DONE: the final word is handshaken (m_valid & m_ready & m_last).
  - DONE -> IDLE: unconditionally, after one cycle. done=1 only while in DONE.
- Issue rule, RUN only:
  - bram_en=1 when (FIFO occupancy + in-flight reads) < FIFO_DEPTH.
  - A pop in the same cycle is not credited.
  - bram_addr = base_addr + issue_count*stride, computed modulo 2^ADDR_W (wrap-around is silent).
  - bram_en=0 in every other state and whenever no credit is available.
- Capture: in the cycle after a bram_en cycle, bram_R_data is pushed into the FIFO on that clock edge. With credits, FIFO overflow is impossible; the bench asserts this.
- Stream:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - A pop occurs when m_valid & m_ready.
  - m_last=1 on the head entry whose beat index equals len-1.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
- Latency: start is accepted in cycle 0. bram_en is first high in cycle 1 and the first m_valid appears in cycle 3. With m_ready held high, throughput is 1 word/cycle.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- abort:
  - In RUN or DRAIN it flushes the FIFO, drops any in-flight read (its return data is ignored next cycle), and moves to IDLE on the next edge. No done pulse is generated.
  - abort in IDLE or DONE has no effect.
  - abort has priority over a simultaneous handshake; that beat is not counted.
- start while busy is ignored, and the latched command is not modified.

Test Plan:
- Basic read: preload BRAM words 0..7 = 0xA0..0xA7; base=0, len=8, stride=4, m_ready=1 -> bram_addr 0,4,...,28 on consecutive cycles; m_data 0xA0..0xA7; m_last with 0xA7; done one cycle after the last handshake; first m_valid 3 cycles after start.
- Strided read: base=0x10, len=3, stride=12 -> addresses 0x10, 0x1C, 0x28; m_data equals the corresponding content words.
- Backpressure: len=10; m_ready toggles 1 cycle on, 3 off -> never more than 4 buffered plus in-flight; no lost or duplicated words; m_data is stable while stalled; bram_en stalls when credits run out.
- Zero length: len=0 -> no bram_en; done pulses in cycle 1; busy high for exactly one cycle.
- Abort: len=16, m_ready=0, assert abort in cycle 6 -> m_valid=0 next cycle, state IDLE, no done. A new start with base=0x40, len=2 returns only the two new words.
- Reset mid-stream and address wrap: assert rst in the middle of a command -> all outputs 0 immediately. base=0xFFFFFFF8, len=3, stride=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0.

Source files
------------

// File: rtl/bram_stream_reader.sv
`default_nettype none

`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef W_REQ_WIDTH
`define W_REQ_WIDTH 4
`endif
`ifndef WRITE_ENB
`define WRITE_ENB 1'b1
`endif

// ============================================================================
// Module : bram_stream_reader
// Desc   : Strided BRAM read master feeding a credit-managed valid/ready FIFO.
// Rev    : 1.0  initial release
// ============================================================================
module bram_stream_reader #(
   parameter int DATA_W     = `DATA_BUS_WIDTH,
   parameter int ADDR_W     = `ADDR_BUS_WIDTH,
   parameter int LEN_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic [LEN_W-1:0]        len,
   input  logic [ADDR_W-1:0]       stride,
   input  logic                    abort,
   output logic                    busy,
   output logic                    done,
   output logic                    bram_en,
   output logic [ADDR_W-1:0]       bram_addr,
   output logic [`W_REQ_WIDTH-1:0] bram_W_req,
   output logic [DATA_W-1:0]       bram_W_data,
   input  logic [DATA_W-1:0]       bram_R_data,
   output logic                    m_valid,
   output logic [DATA_W-1:0]       m_data,
   output logic                    m_last,
   input  logic                    m_ready
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  issue_q, issue_d;
   logic [LEN_W-1:0]  beat_q, beat_d;
   logic              inflight_q, inflight_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

   logic              w_active;
   logic              w_abort;
   logic              w_credit;
   logic              w_issue;
   logic              w_push;
   logic              w_pop;
   logic              w_nonempty;
   logic              w_last_beat;

   assign w_active    = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign w_abort     = abort && w_active;
   // Occupancy plus the read still in flight bounds the FIFO; pops are not credited.
   assign w_credit    = (count_q + CNT_W'(inflight_q)) < C_DEPTH;
   assign w_issue     = (state_q == S_RUN) && (issue_q != len_q) && w_credit;
   assign w_push      = inflight_q;
   assign w_nonempty  = (count_q != '0);
   assign w_pop       = w_nonempty && m_ready;
   assign w_last_beat = (beat_q == (len_q - LEN_W'(1)));

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      stride_d   = stride_q;
      addr_d     = addr_q;
      issue_d    = issue_q;
      beat_d     = beat_q;
      inflight_d = w_issue;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q + CNT_W'(w_push) - CNT_W'(w_pop);

      if (w_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         beat_d   = beat_q + LEN_W'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  state_d  = S_RUN;
                  len_d    = len;
                  stride_d = stride;
                  addr_d   = base_addr;
                  issue_d  = '0;
                  beat_d   = '0;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (w_issue) begin
               issue_d = issue_q + LEN_W'(1);
               addr_d  = addr_q + stride_q;
               if ((issue_q + LEN_W'(1)) == len_q) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (w_pop && w_last_beat) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort discards buffered words and the read whose data returns next cycle.
      if (w_abort) begin
         state_d    = S_IDLE;
         inflight_d = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         stride_q   <= '0;
         addr_q     <= '0;
         issue_q    <= '0;
         beat_q     <= '0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         stride_q   <= stride_d;
         addr_q     <= addr_d;
         issue_q    <= issue_d;
         beat_q     <= beat_d;
         inflight_q <= inflight_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_mem[wr_ptr_q] <= bram_R_data;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign bram_en     = w_issue;
   assign bram_addr   = addr_q;
   assign bram_W_req  = {(`W_REQ_WIDTH){~(`WRITE_ENB)}};
   assign bram_W_data = '0;
   assign m_valid     = w_nonempty;
   assign m_data      = w_nonempty ? fifo_mem[rd_ptr_q] : '0;
   assign m_last      = w_nonempty && w_last_beat;

endmodule

`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none

`ifndef W_REQ_WIDTH
`define W_REQ_WIDTH 4
`endif

// ============================================================================
// Module : tb_bram_stream_reader
// Desc   : Randomised bench for bram_stream_reader with a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bram_stream_reader;

   localparam int DEPTH = 4;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    start = 1'b0;
   logic [31:0]             base_addr = '0;
   logic [15:0]             len = '0;
   logic [31:0]             stride = '0;
   logic                    abort = 1'b0;
   logic                    m_ready = 1'b0;
   logic [31:0]             bram_r_data = '0;
   logic                    busy, done, bram_en, m_valid, m_last;
   logic [31:0]             bram_addr, bram_w_data, m_data;
   logic [`W_REQ_WIDTH-1:0] bram_w_req;

   int n_checks = 0;
   int n_errors = 0;
   int rdy_mode = 0;
   int rdy_phase = 0;

   always #5 clk = ~clk;

   bram_stream_reader #(
      .DATA_W(32), .ADDR_W(32), .LEN_W(16), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .stride(stride), .abort(abort), .busy(busy), .done(done),
      .bram_en(bram_en), .bram_addr(bram_addr), .bram_W_req(bram_w_req),
      .bram_W_data(bram_w_data), .bram_R_data(bram_r_data),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
   );

   // Words 0..7 hold 0xA0..0xA7; every other byte address maps to a distinct pattern.
   function automatic logic [31:0] content(input logic [31:0] a);
      if (a < 32'd32) return 32'hA0 + {29'd0, a[4:2]};
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   always @(posedge clk) begin
      if (bram_en) bram_r_data <= content(bram_addr);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: m_ready = 1'b1;
            1: begin
               m_ready   = (rdy_phase == 0);
               rdy_phase = (rdy_phase + 1) % 4;
            end
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
         endcase
      end
   end

   // Reference model: per-command address/data queues plus issue/pop counts.
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   int  m_len = 0, m_issued = 0, m_popped = 0, h1 = 0, h2 = 0;
   bit  m_active = 0, done_exp = 0, nxt_done = 0, stall_prev = 0;
   bit  abort_eff, exp_en, exp_valid, hs;
   logic [31:0] stall_data = '0;
   logic        stall_last = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         exp_addr.delete(); exp_data.delete();
         m_len = 0; m_issued = 0; m_popped = 0; h1 = 0; h2 = 0;
         m_active = 0; done_exp = 0; stall_prev = 0;
      end else begin
         abort_eff = abort && busy && !done;
         nxt_done  = 0;
         check("done", 32'(done), 32'(done_exp));
         if (stall_prev) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", m_data, stall_data);
            check("stall_last", 32'(m_last), 32'(stall_last));
         end
         exp_valid = m_active && (h2 > m_popped);
         check("m_valid", 32'(m_valid), 32'(exp_valid));
         exp_en = m_active && (m_issued < m_len) && ((m_issued - m_popped) < DEPTH);
         check("bram_en", 32'(bram_en), 32'(exp_en));
         if (bram_en) begin
            check("credit", 32'((m_issued - m_popped) < DEPTH), 32'd1);
            check("w_req", 32'(bram_w_req), 32'd0);
            if (m_issued < m_len) check("bram_addr", bram_addr, exp_addr[m_issued]);
            m_issued++;
         end
         hs = m_valid && m_ready && !abort_eff;
         if (hs) begin
            if (m_popped < m_len) begin
               check("m_data", m_data, exp_data[m_popped]);
               check("m_last", 32'(m_last), 32'(m_popped == m_len - 1));
            end
            if (m_popped == m_len - 1) begin
               nxt_done = 1;
               m_active = 0;
            end
            m_popped++;
         end
         stall_prev = m_valid && !m_ready && !abort_eff;
         stall_data = m_data;
         stall_last = m_last;
         h2 = h1;
         h1 = m_issued;
         if (abort_eff) begin
            exp_addr.delete(); exp_data.delete();
            m_active = 0; m_len = 0; m_issued = 0; m_popped = 0; h1 = 0; h2 = 0;
            nxt_done = 0;
         end
         if (start && !busy) begin
            if (len == 16'd0) begin
               nxt_done = 1;
            end else begin
               exp_addr.delete(); exp_data.delete();
               for (int i = 0; i < int'(len); i++) begin
                  exp_addr.push_back(base_addr + 32'(i) * stride);
                  exp_data.push_back(content(base_addr + 32'(i) * stride));
               end
               m_active = 1; m_len = int'(len); m_issued = 0; m_popped = 0; h1 = 0; h2 = 0;
            end
         end
         done_exp = nxt_done;
      end
   end

   task automatic issue_cmd(input logic [31:0] b, input logic [15:0] l, input logic [31:0] s);
      @(posedge clk); #1;
      base_addr = b; len = l; stride = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      check("done_timeout", 32'(seen), 32'd1);
      @(posedge clk);
   endtask

   task automatic wait_idle(input int budget);
      bit seen = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (!busy) begin
            seen = 1;
            break;
         end
      end
      check("idle_timeout", 32'(seen), 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rb, rs;
      logic [15:0] rl;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_en", 32'(bram_en), 32'd0);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_last", 32'(m_last), 32'd0);
      check("rst_addr", bram_addr, 32'd0);
      check("rst_data", m_data, 32'd0);
      check("rst_wdata", bram_w_data, 32'd0);
      check("rst_wreq", 32'(bram_w_req), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic read with latency checks
      rdy_mode = 0;
      issue_cmd(32'h0, 16'd8, 32'd4);
      @(negedge clk);
      check("lat_en_c1", 32'(bram_en), 32'd1);
      check("lat_addr_c1", bram_addr, 32'd0);
      @(negedge clk);
      check("lat_novalid_c2", 32'(m_valid), 32'd0);
      @(negedge clk);
      check("lat_valid_c3", 32'(m_valid), 32'd1);
      check("first_data", m_data, 32'hA0);
      wait_done(100);

      // Strided read
      issue_cmd(32'h10, 16'd3, 32'd12);
      wait_done(100);

      // Backpressure
      rdy_mode = 1;
      issue_cmd(32'h300, 16'd10, 32'd4);
      wait_done(400);

      // Zero length
      rdy_mode = 0;
      @(negedge clk);
      check("zl_busy_c0", 32'(busy), 32'd0);
      issue_cmd(32'h100, 16'd0, 32'd4);
      @(negedge clk);
      check("zl_done_c1", 32'(done), 32'd1);
      check("zl_busy_c1", 32'(busy), 32'd1);
      check("zl_en_c1", 32'(bram_en), 32'd0);
      @(negedge clk);
      check("zl_done_c2", 32'(done), 32'd0);
      check("zl_busy_c2", 32'(busy), 32'd0);

      // Abort in cycle 6 with the stream stalled
      rdy_mode = 3;
      issue_cmd(32'h200, 16'd16, 32'd4);
      repeat (5) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_valid", 32'(m_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      rdy_mode = 0;
      issue_cmd(32'h40, 16'd2, 32'd4);
      wait_done(100);

      // Reset in the middle of a command
      rdy_mode = 2;
      issue_cmd(32'h1000, 16'd12, 32'd8);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_en", 32'(bram_en), 32'd0);
      check("mid_rst_valid", 32'(m_valid), 32'd0);
      check("mid_rst_last", 32'(m_last), 32'd0);
      check("mid_rst_addr", bram_addr, 32'd0);
      check("mid_rst_data", m_data, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Address wrap-around
      rdy_mode = 0;
      issue_cmd(32'hFFFF_FFF8, 16'd3, 32'd4);
      wait_done(100);

      // Random commands, random backpressure, occasional abort or busy start
      for (int n = 0; n < 14; n++) begin
         rb = $urandom;
         rl = 16'($urandom_range(0, 20));
         rs = 32'($urandom_range(0, 64));
         rdy_mode = $urandom_range(0, 2);
         issue_cmd(rb, rl, rs);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            wait_idle(20);
         end else begin
            if (rl >= 16'd2 && $urandom_range(0, 1) == 1) begin
               base_addr = $urandom; len = 16'd5; stride = 32'd4; start = 1'b1;
               @(posedge clk); #1;
               start = 1'b0;
            end
            wait_done(500);
         end
      end

      repeat (4) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
